seq_pattern_tx: RTL

- Serial pattern transmitter: the generator side of the Mealy sequence-detector datapath.
- Shifts a latched WIDTH-bit pattern (default 1001) onto a 1-bit serial line, MSB first, one bit per clock.
- Supports a programmable repeat count and an idle gap between repetitions.
- Drives detector stimulus in loopback benches and on-chip self-test of the detector.

---
 rtl/seq_pkg.sv | 21 ++
 rtl/seq_piso_shift.sv | 34 +++
 rtl/seq_pattern_tx.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and its detector bench.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Reference pattern, shared with the Mealy detector bench.
  localparam logic [3:0] DEF_PATTERN_1001 = 4'b1001;

  // Gap counter is sized for the full 0..15 gap range.
  localparam int GAP_CW = 4;

  // Width of a down-counter that must hold WIDTH-1.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_piso_shift.sv
// WIDTH-bit parallel-load, MSB-first shift register with a registered serial output.
// The output bit is the bit currently on the line; the register keeps the remaining
// bits aligned so that the next bit to send sits at sreg[WIDTH-2].
module seq_piso_shift #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             dout
);

  logic [WIDTH-1:0] sreg;

  // Load places the MSB on the line immediately; shift advances one bit; clr idles the line.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sreg <= '0;
      dout <= 1'b0;
    end else if (clr) begin
      dout <= 1'b0;
    end else if (load) begin
      sreg <= din;
      dout <= din[WIDTH-1];
    end else if (shift) begin
      sreg <= {sreg[WIDTH-2:0], 1'b0};
      dout <= sreg[WIDTH-2];
    end
  end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB first, with a
// programmable repeat count and an idle gap between repetitions.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | line idle, waiting for start
//   ST_SHIFT | a pattern bit is on op (valid=1); bit_cnt bits remain
//   ST_GAP   | op=0/valid=0 between repetitions; gap_cnt cycles remain
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] DEF_PATTERN = WIDTH'(DEF_PATTERN_1001),
  parameter int               GAP         = 0,
  parameter int               REP_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             use_def,
  input  logic [WIDTH-1:0] pat_in,
  input  logic [REP_W-1:0] rep_in,
  input  logic             abort,
  output logic             op,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int                CW     = cnt_w(WIDTH);
  localparam logic [CW-1:0]     BIT_LD = CW'(WIDTH - 1);
  localparam logic [GAP_CW-1:0] GAP_LD = (GAP > 0) ? GAP_CW'(GAP - 1) : '0;

  state_t state, state_d;

  logic [WIDTH-1:0]  pat_q;
  logic [WIDTH-1:0]  pat_sel;
  logic [WIDTH-1:0]  load_pat;
  logic [REP_W-1:0]  rep_cnt;
  logic [CW-1:0]     bit_cnt;
  logic [GAP_CW-1:0] gap_cnt;

  logic sh_clr, sh_load, sh_shift;
  logic valid_d, busy_d, done_d;

  logic last_bit;

  assign pat_sel  = use_def ? DEF_PATTERN : pat_in;
  assign load_pat = (state == ST_IDLE) ? pat_sel : pat_q;
  assign last_bit = (bit_cnt == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next-state decode; abort wins over everything except reset.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (start && !abort) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (last_bit) begin
          if (rep_cnt == '0) state_d = ST_IDLE;
          else if (GAP > 0)  state_d = ST_GAP;
          else               state_d = ST_SHIFT;
        end
      end
      ST_GAP: begin
        if (abort)                state_d = ST_IDLE;
        else if (gap_cnt == '0)   state_d = ST_SHIFT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: shifter control plus next values of the registered flags.
  always_comb begin
    sh_clr   = 1'b0;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    done_d   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) sh_load = 1'b1;
        else                 sh_clr  = 1'b1;
      end
      ST_SHIFT: begin
        if (abort) begin
          sh_clr = 1'b1;
        end else if (!last_bit) begin
          sh_shift = 1'b1;
        end else if (rep_cnt != '0 && GAP == 0) begin
          sh_load = 1'b1;
        end else begin
          sh_clr = 1'b1;
          done_d = (rep_cnt == '0);
        end
      end
      ST_GAP: begin
        if (!abort && gap_cnt == '0) sh_load = 1'b1;
        else                         sh_clr  = 1'b1;
      end
      default: sh_clr = 1'b1;
    endcase
    valid_d = (state_d == ST_SHIFT);
    busy_d  = (state_d != ST_IDLE);
  end

  // Pattern latch, down-counters and registered status flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pat_q   <= '0;
      rep_cnt <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      valid <= valid_d;
      busy  <= busy_d;
      done  <= done_d;
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            pat_q   <= pat_sel;
            rep_cnt <= rep_in;
            bit_cnt <= BIT_LD;
          end
        end
        ST_SHIFT: begin
          if (!abort) begin
            if (!last_bit) begin
              bit_cnt <= bit_cnt - 1'b1;
            end else if (rep_cnt != '0) begin
              rep_cnt <= rep_cnt - 1'b1;
              if (GAP > 0) gap_cnt <= GAP_LD;
              else         bit_cnt <= BIT_LD;
            end
          end
        end
        ST_GAP: begin
          if (!abort) begin
            if (gap_cnt == '0) bit_cnt <= BIT_LD;
            else               gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  seq_piso_shift #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk   (clk),
    .reset (reset),
    .clr   (sh_clr),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (load_pat),
    .dout  (op)
  );

endmodule
